// File: rtl/voter_plus.sv
// Weighted vote tally: 32 normal, 8 VIP and 1 VVIP voters, votes latched per clock.
// Build option VOTE_TOGGLE_EN: each rising request edge toggles that voter's vote.
module voter_plus #(
    parameter int NP_W        = 32,
    parameter int VIP_W       = 8,
    parameter int NP_WEIGHT   = 1,
    parameter int VIP_WEIGHT  = 4,
    parameter int VVIP_WEIGHT = 16,
    parameter int RES_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NP_W-1:0]  np,
    input  logic [VIP_W-1:0] vip,
    input  logic             vvip,
    output logic [RES_W-1:0] result
);

    logic [NP_W-1:0]  np_q;
    logic [VIP_W-1:0] vip_q;
    logic             vvip_q;
    logic [RES_W-1:0] acc;

`ifdef VOTE_TOGGLE_EN
    logic [NP_W-1:0]  prev_np;
    logic [VIP_W-1:0] prev_vip;
    logic             prev_vvip;

    // A flag flips only on a 0->1 edge of its request, so a held request toggles once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            np_q      <= '0;
            vip_q     <= '0;
            vvip_q    <= 1'b0;
            prev_np   <= '0;
            prev_vip  <= '0;
            prev_vvip <= 1'b0;
        end else begin
            np_q      <= np_q ^ (np & ~prev_np);
            vip_q     <= vip_q ^ (vip & ~prev_vip);
            vvip_q    <= vvip_q ^ (vvip & ~prev_vvip);
            prev_np   <= np;
            prev_vip  <= vip;
            prev_vvip <= vvip;
        end
    end
`else
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            np_q   <= '0;
            vip_q  <= '0;
            vvip_q <= 1'b0;
        end else begin
            np_q   <= np_q | np;
            vip_q  <= vip_q | vip;
            vvip_q <= vvip_q | vvip;
        end
    end
`endif

    // Tally depends on the latched flags only, never on the raw request lines.
    always_comb begin
        acc = '0;
        for (int unsigned i = 0; i < NP_W; i++) begin
            if (np_q[i]) acc = acc + RES_W'(NP_WEIGHT);
        end
        for (int unsigned j = 0; j < VIP_W; j++) begin
            if (vip_q[j]) acc = acc + RES_W'(VIP_WEIGHT);
        end
        if (vvip_q) acc = acc + RES_W'(VVIP_WEIGHT);
        result = acc;
    end

endmodule

// File: tb/tb_voter_plus.sv
// Bench for voter_plus: directed vector table, hand sequences for async reset,
// and randomized traffic against a set-based reference model.
module tb_voter_plus;

    logic        clk;
    logic        reset;
    logic [31:0] np;
    logic [7:0]  vip;
    logic        vvip;
    logic [7:0]  result;

    int total;
    int bad;

    voter_plus #(
        .NP_W(32), .VIP_W(8), .NP_WEIGHT(1), .VIP_WEIGHT(4), .VVIP_WEIGHT(16), .RES_W(8)
    ) dut (
        .clk(clk), .reset(reset), .np(np), .vip(vip), .vvip(vvip), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] np;
        logic [7:0]  vip;
        logic        vvip;
        int          exp;
    } vec_t;

    vec_t vecs[$];

    // Reference model: which voters currently hold a vote, plus last request seen.
    logic [31:0] m_np, m_prev_np;
    logic [7:0]  m_vip, m_prev_vip;
    logic        m_vvip, m_prev_vvip;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: result=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic edge_with(input logic [31:0] n, input logic [7:0] v, input logic vv);
        np = n; vip = v; vvip = vv;
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_np = '0; m_vip = '0; m_vvip = 1'b0;
        m_prev_np = '0; m_prev_vip = '0; m_prev_vvip = 1'b0;
    endtask

    task automatic model_edge(input logic [31:0] n, input logic [7:0] v, input logic vv);
`ifdef VOTE_TOGGLE_EN
        for (int i = 0; i < 32; i++) if (n[i] && !m_prev_np[i]) m_np[i] = !m_np[i];
        for (int j = 0; j < 8; j++)  if (v[j] && !m_prev_vip[j]) m_vip[j] = !m_vip[j];
        if (vv && !m_prev_vvip) m_vvip = !m_vvip;
`else
        for (int i = 0; i < 32; i++) if (n[i]) m_np[i] = 1'b1;
        for (int j = 0; j < 8; j++)  if (v[j]) m_vip[j] = 1'b1;
        if (vv) m_vvip = 1'b1;
`endif
        m_prev_np = n; m_prev_vip = v; m_prev_vvip = vv;
    endtask

    function automatic int model_result();
        return $countones(m_np) * 1 + $countones(m_vip) * 4 + (m_vvip ? 16 : 0);
    endfunction

    task automatic hard_reset(input int cycles);
        np = '0; vip = '0; vvip = 1'b0;
        reset = 1'b0;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check("reset_hold", int'(result), 0);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        reset = 1'b0;
        np = '0; vip = '0; vvip = 1'b0;
        model_clear();

        // Reset then idle.
        #2;
        check("reset_async_initial", int'(result), 0);
        hard_reset(2);
        for (int k = 0; k < 3; k++) begin
            edge_with('0, '0, 1'b0);
            check("idle_after_reset", int'(result), 0);
        end

        // One-cycle mixed vote, then 10 idle cycles.
        vecs.push_back('{32'h8888_8888, 8'h88, 1'b1, 32});
        for (int k = 0; k < 10; k++) vecs.push_back('{32'h0, 8'h00, 1'b0, 32});
        foreach (vecs[k]) begin
            edge_with(vecs[k].np, vecs[k].vip, vecs[k].vvip);
            check($sformatf("mixed_vote[%0d]", k), int'(result), vecs[k].exp);
        end

        // Asynchronous reset between edges with result at 32.
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_reset_mid", int'(result), 0);
        #2;
        reset = 1'b1;
        check("async_reset_still_zero", int'(result), 0);

        // Accumulation across cycles starting from zero.
        vecs.delete();
        vecs.push_back('{32'h1, 8'h00, 1'b0, 1});
        vecs.push_back('{32'h0, 8'h01, 1'b0, 5});
`ifdef VOTE_TOGGLE_EN
        vecs.push_back('{32'h1, 8'h00, 1'b0, 4});
`else
        vecs.push_back('{32'h1, 8'h00, 1'b0, 5});
`endif
        foreach (vecs[k]) begin
            edge_with(vecs[k].np, vecs[k].vip, vecs[k].vvip);
            check($sformatf("accumulate[%0d]", k), int'(result), vecs[k].exp);
        end

        // Full vote from a clean state, held for 5 more cycles.
        hard_reset(1);
        for (int k = 0; k < 6; k++) begin
            edge_with('1, 8'hFF, 1'b1);
            check($sformatf("full_vote[%0d]", k), int'(result), 80);
        end

        // Inputs changing between edges are ignored until the next edge.
        hard_reset(1);
        @(negedge clk);
        np = 32'hF; vip = 8'h3; vvip = 1'b1;
        #2;
        check("no_effect_between_edges", int'(result), 0);
        np = '0; vip = '0; vvip = 1'b0;
        @(posedge clk);
        #1;
        check("withdrawn_before_edge", int'(result), 0);

`ifdef VOTE_TOGGLE_EN
        hard_reset(1);
        edge_with('0, 8'h01, 1'b0);
        check("toggle_pulse_on", int'(result), 4);
        edge_with('0, 8'h00, 1'b0);
        check("toggle_idle_on", int'(result), 4);
        edge_with('0, 8'h01, 1'b0);
        check("toggle_pulse_off", int'(result), 0);
        edge_with('0, 8'h00, 1'b0);
        check("toggle_idle_off", int'(result), 0);
        for (int k = 0; k < 4; k++) begin
            edge_with('0, 8'h01, 1'b0);
            check($sformatf("toggle_hold[%0d]", k), int'(result), 4);
        end
`endif

        // Randomized traffic against the reference model, with occasional async resets.
        hard_reset(1);
        model_clear();
        for (int k = 0; k < 400; k++) begin
            logic [31:0] rn;
            logic [7:0]  rv;
            logic        rvv;
            rn  = $urandom & $urandom & $urandom & $urandom;
            rv  = 8'($urandom & $urandom & $urandom);
            rvv = ($urandom_range(0, 9) == 0);
            edge_with(rn, rv, rvv);
            model_edge(rn, rv, rvv);
            check("random_vs_model", int'(result), model_result());
            if ($urandom_range(0, 39) == 0) begin
                reset = 1'b0;
                #1;
                model_clear();
                check("random_async_reset", int'(result), 0);
                reset = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
